// File: rtl/sd_clk_gen_if.sv
// Control/status bundle for the SD bus clock generator.
// SD_CLKGEN_HOLD_EN adds the hold (flow-control) signal.
interface sd_clk_gen_if #(
  parameter int DIV_W = 8
) ();
  logic             en;
  logic [DIV_W-1:0] div_i;
  logic             div_load;
  logic             div_ack;
  logic             sd_clk;
  logic             rise_stb;
  logic             fall_stb;
  logic             running;
`ifdef SD_CLKGEN_HOLD_EN
  logic             hold;
`endif

  modport master (
    output en, div_i, div_load,
`ifdef SD_CLKGEN_HOLD_EN
    output hold,
`endif
    input  div_ack, sd_clk, rise_stb, fall_stb, running
  );

  modport slave (
    input  en, div_i, div_load,
`ifdef SD_CLKGEN_HOLD_EN
    input  hold,
`endif
    output div_ack, sd_clk, rise_stb, fall_stb, running
  );
endinterface

// File: rtl/sd_clk_gen.sv
// SD bus clock generator: programmable divider with launch/sample strobes,
// glitch-free start/stop and deferred divisor changes. SD_CLKGEN_HOLD_EN adds hold/PAUSE.
module sd_clk_gen #(
  parameter int          DIV_W   = 8,
  parameter int unsigned DIV_RST = 33
) (
  input logic         clk,
  input logic         rst,
  sd_clk_gen_if.slave bus
);

`ifdef SD_CLKGEN_HOLD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  state_t           state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_act_r;
  logic [DIV_W-1:0] div_pend_r;
  logic             pend_r;
  logic             sd_clk_r;
  logic             rise_r;
  logic             fall_r;
  logic             ack_r;
  logic             running_r;

  logic             hold_s;
  logic             stop_s;
  logic             hit_s;
  logic             apply_s;
  logic [DIV_W-1:0] new_div_s;
  state_t           stop_tgt_s;

`ifdef SD_CLKGEN_HOLD_EN
  assign hold_s = bus.hold;
`else
  assign hold_s = 1'b0;
`endif

  assign stop_s = !bus.en || hold_s;
  assign hit_s  = (cnt_r == div_act_r);

  // Divisor to install at an apply point: a load in the same cycle beats an older pending one.
  always_comb begin
    apply_s   = 1'b0;
    new_div_s = div_act_r;
    if (bus.div_load) begin
      apply_s   = 1'b1;
      new_div_s = bus.div_i;
    end else if (pend_r) begin
      apply_s   = 1'b1;
      new_div_s = div_pend_r;
    end else begin
      apply_s   = 1'b0;
      new_div_s = div_act_r;
    end
  end

  // Where a stop request lands: a hold with the bus still enabled parks in PAUSE.
  always_comb begin
    stop_tgt_s = IDLE;
`ifdef SD_CLKGEN_HOLD_EN
    if (bus.en) begin
      stop_tgt_s = PAUSE;
    end else begin
      stop_tgt_s = IDLE;
    end
`endif
  end

  // Main sequencer: state, half-period counter, divisor bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      div_act_r  <= DIV_RST_V;
      div_pend_r <= '0;
      pend_r     <= 1'b0;
      sd_clk_r   <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      ack_r      <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r    <= '0;
          sd_clk_r <= 1'b0;
          pend_r   <= 1'b0;
          if (bus.div_load) begin
            div_act_r <= bus.div_i;
            ack_r     <= 1'b1;
          end
          state_r   <= bus.en ? RUN : IDLE;
          running_r <= bus.en;
        end
`ifdef SD_CLKGEN_HOLD_EN
        PAUSE: begin
          cnt_r    <= '0;
          sd_clk_r <= 1'b0;
          pend_r   <= 1'b0;
          if (bus.div_load) begin
            div_act_r <= bus.div_i;
            ack_r     <= 1'b1;
          end
          if (!bus.en) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
          end else if (!hold_s) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= PAUSE;
            running_r <= 1'b1;
          end
        end
`endif
        RUN: begin
          if (bus.div_load) begin
            div_pend_r <= bus.div_i;
            pend_r     <= 1'b1;
          end
          if (!sd_clk_r && stop_s) begin
            // Low phase: stopping here cannot shorten a high phase.
            cnt_r     <= '0;
            pend_r    <= 1'b0;
            state_r   <= stop_tgt_s;
            running_r <= (stop_tgt_s != IDLE);
            if (apply_s) begin
              div_act_r <= new_div_s;
              ack_r     <= 1'b1;
            end
          end else if (hit_s) begin
            cnt_r    <= '0;
            sd_clk_r <= ~sd_clk_r;
            if (sd_clk_r) begin
              fall_r <= 1'b1;
              pend_r <= 1'b0;
              if (apply_s) begin
                div_act_r <= new_div_s;
                ack_r     <= 1'b1;
              end
              if (stop_s) begin
                state_r   <= stop_tgt_s;
                running_r <= (stop_tgt_s != IDLE);
              end
            end else begin
              rise_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1'b1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          sd_clk_r  <= 1'b0;
          pend_r    <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sd_clk   = sd_clk_r;
  assign bus.rise_stb = rise_r;
  assign bus.fall_stb = fall_r;
  assign bus.div_ack  = ack_r;
  assign bus.running  = running_r;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: edge-schedule reference model compared every cycle,
// plus hand-computed edge timings. Define SD_CLKGEN_HOLD_EN to also cover hold/PAUSE.
module tb_sd_clk_gen;
  logic clk = 1'b0;
  logic rst;

  sd_clk_gen_if #(.DIV_W(8)) bus ();

  sd_clk_gen #(.DIV_W(8), .DIV_RST(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int ack_cnt = 0;

  logic hold_v;
`ifdef SD_CLKGEN_HOLD_EN
  assign hold_v = bus.hold;
`else
  assign hold_v = 1'b0;
`endif

  // Reference model: the bus clock is a schedule of toggle edges; each toggle
  // books the next one (divisor+1) edges later. States: 0 idle, 1 run, 2 pause.
  int       m_state = 0;
  int       m_next  = 0;
  bit       m_lvl, m_rise, m_fall, m_ack, m_pend, m_valid;
  bit [7:0] m_div = 8'd33;
  bit [7:0] m_pv  = 8'd0;

  task automatic m_apply();
    if (bus.div_load) begin
      m_div = bus.div_i;
      m_ack = 1'b1;
    end else if (m_pend) begin
      m_div = m_pv;
      m_ack = 1'b1;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    bit stop;
    cyc++;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_ack  = 1'b0;
    stop   = !bus.en || hold_v;
    if (rst) begin
      m_state = 0; m_lvl = 1'b0; m_div = 8'd33; m_pend = 1'b0; m_valid = 1'b1;
    end else if (m_state != 1) begin
      if (bus.div_load) begin
        m_div = bus.div_i;
        m_ack = 1'b1;
      end
      if (m_state == 0 && bus.en) begin
        m_state = 1;
        m_next  = cyc + int'(m_div) + 1;
      end else if (m_state == 2 && !bus.en) begin
        m_state = 0;
      end else if (m_state == 2 && !hold_v) begin
        m_state = 1;
        m_next  = cyc + int'(m_div) + 1;
      end
    end else begin
      if (!m_lvl && stop) begin
        m_apply();
        m_state = bus.en ? 2 : 0;
      end else if (cyc == m_next && m_lvl) begin
        m_fall = 1'b1;
        m_lvl  = 1'b0;
        m_apply();
        if (stop) m_state = bus.en ? 2 : 0;
        m_next = cyc + int'(m_div) + 1;
      end else begin
        if (cyc == m_next) begin
          m_rise = 1'b1;
          m_lvl  = 1'b1;
          m_next = cyc + int'(m_div) + 1;
        end
        if (bus.div_load) begin
          m_pend = 1'b1;
          m_pv   = bus.div_i;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if ({bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.div_ack, bus.running} !==
          {m_lvl, m_rise, m_fall, m_ack, (m_state != 0)}) begin
        fails++;
        $display("FAIL cycle %0d outputs sd_clk/rise/fall/ack/running: got %b%b%b%b%b expected %b%b%b%b%b",
                 cyc, bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.div_ack, bus.running,
                 m_lvl, m_rise, m_fall, m_ack, (m_state != 0));
      end
      if (bus.div_ack) ack_cnt++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Waits (bounded) for a rise or fall strobe; returns the edge index that produced it.
  task automatic wait_edge(input bit want_rise, output int e);
    e = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (want_rise ? bus.rise_stb : bus.fall_stb) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) begin
      vectors++;
      fails++;
      $display("FAIL timeout waiting for %s strobe: got none expected one within 300 cycles",
               want_rise ? "rise" : "fall");
    end
  endtask

  initial begin
    int n, r, f, r2, f2, r3, a0, cnt;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_i    = 8'd0;
`ifdef SD_CLKGEN_HOLD_EN
    bus.hold     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.div_ack, bus.running}), 0);
    rst = 1'b0;

    // Start at the reset divisor: first rise D+1 edges after RUN entry, 68-cycle period.
    @(negedge clk);
    bus.en = 1'b1;
    n = cyc + 1;
    wait_edge(1'b1, r);
    check("first_rise_d33", r - n, 34);
    wait_edge(1'b0, f);
    check("high_phase_d33", f - r, 34);
    wait_edge(1'b1, r2);
    check("period_d33", r2 - r, 68);

    // Load D=0 mid-high-phase: current high phase completes, then clk/2.
    repeat (10) @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_i    = 8'd0;
    @(negedge clk);
    bus.div_load = 1'b0;
    wait_edge(1'b0, f);
    check("fall_after_load", f - r2, 34);
    check("ack_at_apply", int'(bus.div_ack), 1);
    wait_edge(1'b1, r);
    check("rise_d0", r - f, 1);
    wait_edge(1'b0, f2);
    check("fall_d0", f2 - r, 1);

    // Stop, then reload 33 while idle.
    @(negedge clk);
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    check("stopped_running", int'(bus.running), 0);
    bus.div_load = 1'b1;
    bus.div_i    = 8'd33;
    @(negedge clk);
    bus.div_load = 1'b0;
    check("idle_load_ack", int'(bus.div_ack), 1);
    @(negedge clk);
    check("idle_ack_one_cycle", int'(bus.div_ack), 0);

    // en dropped 5 cycles into a high phase: high phase still runs its full length.
    bus.en = 1'b1;
    n = cyc + 1;
    wait_edge(1'b1, r);
    check("restart_rise", r - n, 34);
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    wait_edge(1'b0, f);
    check("stop_fall_not_truncated", f - r, 34);
    @(negedge clk);
    check("stop_running_low", int'(bus.running), 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.rise_stb || bus.sd_clk) cnt++;
    end
    check("no_rise_after_stop", cnt, 0);

    // Two loads (3 then 1) in one high phase: last wins, one ack, period 4.
    bus.en = 1'b1;
    n = cyc + 1;
    wait_edge(1'b1, r);
    check("rise_before_double_load", r - n, 34);
    a0 = ack_cnt;
    repeat (3) @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_i    = 8'd3;
    @(negedge clk);
    bus.div_load = 1'b0;
    repeat (2) @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_i    = 8'd1;
    @(negedge clk);
    bus.div_load = 1'b0;
    wait_edge(1'b0, f);
    check("double_load_fall", f - r, 34);
    wait_edge(1'b1, r2);
    check("low_phase_d1", r2 - f, 2);
    wait_edge(1'b0, f2);
    check("high_phase_d1", f2 - r2, 2);
    wait_edge(1'b1, r3);
    check("period_d1", r3 - r2, 4);
    check("single_ack", ack_cnt - a0, 1);

    // Reset while sd_clk is high: everything back to reset values, divisor 33.
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_high", int'({bus.sd_clk, bus.rise_stb, bus.fall_stb, bus.div_ack, bus.running}), 0);
    rst = 1'b0;
    n = cyc + 1;
    wait_edge(1'b1, r);
    check("divisor_after_reset", r - n, 34);
    bus.en = 1'b0;
    repeat (40) @(negedge clk);

`ifdef SD_CLKGEN_HOLD_EN
    // Hold for 100 cycles at D=1: parks low in PAUSE, restarts D+1 cycles after release.
    bus.div_load = 1'b1;
    bus.div_i    = 8'd1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.en       = 1'b1;
    n = cyc + 1;
    wait_edge(1'b1, r);
    check("hold_first_rise", r - n, 2);
    bus.hold = 1'b1;
    wait_edge(1'b0, f);
    check("hold_fall", f - r, 2);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.running || bus.sd_clk) cnt++;
    end
    check("pause_low_and_running", cnt, 0);
    bus.hold = 1'b0;
    n = cyc + 1;
    wait_edge(1'b1, r2);
    check("rise_after_hold", r2 - n, 2);
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sd_clk_gen.md
# sd_clk_gen

- Generates the SD card bus clock (`sd_clk`) from the single fabric clock using a programmable counter.
- Provides single-cycle rise/fall strobes so the command and data engines can launch and sample in the fabric clock domain.
- Sits between the fixed hard-macro clock divider output and the SD command/data paths.
- Supports a glitch-free start/stop, and a run-time divisor change from the ≤400 kHz identification rate to the transfer rate.

## Interface

Parameters:
- `DIV_W`, 8: width of the divisor.
- `DIV_RST`, 33: divisor loaded at reset. 27 MHz / (2·34) ≈ 397 kHz, the identification rate.

Ports:
- `clk` input 1: the single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: request bus clock running.
- `div_i` input DIV_W: new divisor D. Half-period is D+1 `clk` cycles.
- `div_load` input 1: one-cycle strobe; capture `div_i`.
- `div_ack` output 1: one-cycle pulse when the captured divisor becomes active.
- `sd_clk` output 1: registered bus clock; idles low.
- `rise_stb` output 1: high during the first `clk` cycle in which `sd_clk`=1.
- `fall_stb` output 1: high during the first `clk` cycle in which `sd_clk`=0 after a high phase.
- `running` output 1: high whenever state ≠ IDLE.
- `hold` input 1: present only with `SD_CLKGEN_HOLD_EN`.

## Operation

- Registers:
  - `div_act` (active divisor)
  - `div_pend` plus a pending flag
  - `cnt` (DIV_W bits)
  - `sd_clk`
  - state ∈ {IDLE, RUN, PAUSE}
- **Reset:** state=IDLE, `cnt`=0, `div_act`=DIV_RST, pending=0, `sd_clk`=0. `rise_stb`, `fall_stb`, `div_ack` and `running` are all 0.
- **IDLE:**
  - `sd_clk` is held 0 and `cnt` is held 0.
  - `en`=1 moves the block to RUN.
  - `div_load` in IDLE writes `div_act` directly and pulses `div_ack` on the next cycle.
- **RUN:**
  - `cnt` increments each cycle.
  - When `cnt`==`div_act`, `sd_clk` toggles and `cnt` clears. Period = 2·(`div_act`+1) cycles, 50% duty. D=0 gives `clk`/2.
- **Divisor change in RUN:**
  - `div_load` stores `div_i` in `div_pend` and sets pending.
  - The new value is applied at the next falling toggle, so the new low phase already uses it. `div_ack` pulses the cycle after that toggle.
  - Repeated loads before the apply point: last value wins, one `div_ack`.
  - A load coinciding with the falling toggle edge is applied at that toggle.
- **Stop (`en`=0 sampled in RUN):**
  - If `sd_clk`=1, keep counting until the falling toggle, then go to IDLE. That fall still produces `fall_stb`.
  - If `sd_clk`=0, go to IDLE at once, with `cnt` cleared.
  - No high phase is ever truncated.
- **Arithmetic:** `cnt` compares with equality only. `cnt` never exceeds `div_act` because `cnt` clears on every apply.
- **Reset mid-operation:** behaves as the reset state on the next cycle. `sd_clk` drops even mid-high-phase; this is acceptable because the card is reinitialised.

## Timing

- `en` sampled high at edge N in IDLE:
  - state=RUN after N.
  - First `sd_clk` rise at edge N+1+D; `rise_stb`=1 during the cycle after that edge.
  - `running`=1 from edge N.
- Strobes are registered alongside `sd_clk`. Each is exactly one cycle wide and asserted in the same cycle as the new `sd_clk` level.
- `en` and `div_load` are sampled every cycle.

## Configuration

- `SD_CLKGEN_HOLD_EN` defined:
  - Adds the `hold` input and the PAUSE state, used for flow control when the data buffer is full or empty.
  - `hold`=1 in RUN stops the clock exactly as `en`=0 does, except the state becomes PAUSE and `running` stays 1.
  - From PAUSE, `hold`=0 with `en`=1 returns to RUN with `cnt`=0, giving the first rise after D+1 cycles.
  - From PAUSE, `en`=0 goes to IDLE.
  - Pending divisor loads still apply at the falling toggle, or on entry to PAUSE if none occurs.
- Not defined: no `hold` port and no PAUSE state. Behaviour is identical to `hold` tied 0.

## Test plan

- Reset, then `en`=1 with DIV_RST=33 → first rise 34 cycles after RUN entry, then a 68-cycle period at 50% duty, one `rise_stb`/`fall_stb` per edge.
- `div_load` with `div_i`=0 while in RUN, mid-high-phase → current high phase lasts 34 cycles; from the fall onward period=2; `div_ack` pulses once, one cycle after the fall.
- `en` dropped 5 cycles into a high phase (D=33) → `sd_clk` stays high for the remaining 29 cycles, falls with `fall_stb`, `running`=0 next cycle, no further rise.
- Two `div_load`s (values 3, then 1) within one high phase → only 1 applies, single `div_ack`, period becomes 4.
- `rst` asserted while `sd_clk`=1 → next cycle: `sd_clk`=0, all strobes and `div_ack`=0, `running`=0, divisor=33.
- With `SD_CLKGEN_HOLD_EN`: `hold`=1 for 100 cycles during RUN (D=1) → clock stops low after the next fall, `running`=1 throughout; after `hold` drops, first rise follows 2 cycles later.
